alu_regfile: RTL and testbench
==============================

// Module: alu_regfile
// PURPOSE
//   Execute-stage datapath core of the single-cycle RV32I CPU.
//   Holds the 32-entry integer register file (x0..x31), with two combinational read ports and one
//   synchronous write port.
//   Also holds a purely combinational 32-bit ALU.
//   Decode and control logic drive the ALU operands and operation code, and select the writeback data.
// PARAMETERS
//   DATA_W  32  register/ALU data width (RV32)
//   ADDR_W  5   register address width; 2**ADDR_W registers
// PORTS
//   clk           in   1       system clock; all state updates on rising edge
//   rst_n         in   1       reset, synchronous, active-low
//   raddr1        in   5       read port 1 address (rs1)
//   rdata1        out  32      read port 1 data
//   raddr2        in   5       read port 2 address (rs2)
//   rdata2        out  32      read port 2 data
//   we            in   1       register write enable
//   waddr         in   5       write address (rd)
//   wdata         in   32      write data
//   alu_src1      in   32      ALU operand A
//   alu_src2      in   32      ALU operand B
//   alu_op        in   4       ALU operation select
//   alu_result    out  32      ALU result
//   alu_zero      out  1       1 when alu_result == 0
//   alu_negative  out  1       alu_result[31]
// BEHAVIOUR
//   Interface: one clock (clk); reset is synchronous and active-low (rst_n).
//   Register file
//   - Reset: when rst_n==0 at a clk rising edge, all registers are set to 0 and any write that cycle
//     is ignored. After reset, rdata1 and rdata2 read 0 for every address.
//   - Read: rdataN = reg[raddrN], combinational, with zero cycles of latency.
//   - x0: a read of address 0 always returns 0. A write to address 0 is discarded.
//   - Write: at a rising edge with rst_n==1, we==1 and waddr!=0, reg[waddr] <= wdata.
//   - Read-during-write: the read returns the OLD value until the edge, with no bypass.
//     The new value is visible immediately after the edge.
//   ALU (combinational, ignores clk/rst_n); A=alu_src1, B=alu_src2, sh=B[4:0]
//   - 4'h0 ADD  A+B, modulo 2^32, carry discarded
//   - 4'h1 SUB  A-B, modulo 2^32
//   - 4'h2 SLL  A << sh
//   - 4'h3 SLT  {31'b0, $signed(A) < $signed(B)}
//   - 4'h4 SLTU {31'b0, A < B} (unsigned)
//   - 4'h5 XOR  A ^ B
//   - 4'h6 SRL  A >> sh (logical)
//   - 4'h7 SRA  $signed(A) >>> sh (arithmetic)
//   - 4'h8 OR   A | B
//   - 4'h9 AND  A & B
//   - 4'hA..4'hF: alu_result = 0, so alu_zero=1 and alu_negative=0.
//   - Shifts use only B[4:0]; B[31:5] is ignored.
//   - alu_zero  = (alu_result == 32'h0).
//   - alu_negative = alu_result[31].
//   - No latches and no X propagation for any alu_op value.
// TESTING
//   - Reset: hold rst_n=0 for 1 edge, with we=1, waddr=5, wdata=32'hDEAD at that edge.
//     Required: rdata1 and rdata2 read 0 for all 32 addresses, and x5 reads 0.
//   - Write/read: we=1, waddr=3, wdata=32'h1234_5678.
//     Before the edge, raddr1=3 reads 0; after the edge it reads 32'h1234_5678.
//     Then write x0=32'hFFFF_FFFF; raddr2=0 must still read 0.
//   - Arithmetic: ADD 32'hFFFF_FFFF+1 gives 0 with alu_zero=1.
//     SUB 0-1 gives 32'hFFFF_FFFF with alu_negative=1.
//   - Compares: SLT(32'hFFFF_FFFF, 1) gives 1, while SLTU on the same operands gives 0.
//     SLT(5,5) gives 0 with alu_zero=1.
//   - Shifts: SLL(1, 32'h0000_0024) gives 32'h10 (only sh=4 used).
//     SRL(32'h8000_0000, 31) gives 1.
//     SRA(32'h8000_0000, 4) gives 32'hF800_0000.
//   - Logic/undefined: XOR/OR/AND with 32'hF0F0_F0F0 and 32'hFF00_FF00 give 32'h0FF0_0FF0,
//     32'hFFF0_FFF0 and 32'hF000_F000 respectively.
//     alu_op=4'hC gives result 0 with alu_zero=1.

Source files
------------

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
//   Execute-stage datapath core of a single-cycle RV32I CPU.  It has two
//   parts:
//   - The integer register file, x0..x31.  It has two combinational read
//     ports and one synchronous write port.  x0 always reads as zero.
//   - A purely combinational 32-bit ALU that takes its operands and opcode
//     from decode/control.
//
// Ports
//   clk           in   1       system clock, rising edge
//   rst_n         in   1       synchronous active-low reset (clears all regs)
//   raddr1/2      in   ADDR_W  read port addresses (rs1/rs2)
//   rdata1/2      out  DATA_W  read port data, zero-latency
//   we            in   1       register write enable
//   waddr         in   ADDR_W  write address (rd)
//   wdata         in   DATA_W  write data
//   alu_src1/2    in   DATA_W  ALU operands A/B
//   alu_op        in   4       ALU operation select
//   alu_result    out  DATA_W  ALU result
//   alu_zero      out  1       alu_result == 0
//   alu_negative  out  1       alu_result MSB
// ---------------------------------------------------------------------------
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] alu_src1,
  input  logic [DATA_W-1:0] alu_src2,
  input  logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_zero,
  output logic              alu_negative
);

  localparam int NREGS = 1 << ADDR_W;
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_SLTU = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_reg [NREGS];

  // Entry 0 is cleared by reset and is never written.  The read path also
  // forces it to zero, so x0 does not depend on that storage slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_reg[waddr] <= wdata;
    end
  end

  // The read ports have no write bypass.  A read during a write returns the
  // old value until the edge.
  assign rdata1 = (raddr1 == '0) ? '0 : regs_reg[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_reg[raddr2];

  // -------------------------------------------------------------------------
  // ALU
  // -------------------------------------------------------------------------
  logic [SH_W-1:0] sh;
  logic            lt_signed;
  logic            lt_unsigned;

  // Shift amounts use only the low log2(DATA_W) bits of operand B.
  assign sh          = alu_src2[SH_W-1:0];
  assign lt_signed   = $signed(alu_src1) < $signed(alu_src2);
  assign lt_unsigned = alu_src1 < alu_src2;

  always_comb begin
    alu_result = '0;  // unused opcodes 4'hA..4'hF produce zero
    case (alu_op)
      OP_ADD:  alu_result = alu_src1 + alu_src2;
      OP_SUB:  alu_result = alu_src1 - alu_src2;
      OP_SLL:  alu_result = alu_src1 << sh;
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, lt_signed};
      OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, lt_unsigned};
      OP_XOR:  alu_result = alu_src1 ^ alu_src2;
      OP_SRL:  alu_result = alu_src1 >> sh;
      OP_SRA:  alu_result = $unsigned($signed(alu_src1) >>> sh);
      OP_OR:   alu_result = alu_src1 | alu_src2;
      OP_AND:  alu_result = alu_src1 & alu_src2;
      default: alu_result = '0;
    endcase
  end

  assign alu_zero     = (alu_result == '0);
  assign alu_negative = alu_result[DATA_W-1];

endmodule

// File: tb/tb_alu_regfile.sv
// ---------------------------------------------------------------------------
// tb_alu_regfile
//   Self-checking bench for alu_regfile.  Expected values are pushed to a
//   scoreboard queue when stimulus is driven.  They are popped and compared
//   when the DUT output is sampled, away from the rising clock edge.  ALU
//   checks come from a vector table.  The register file checks are
//   hand-written sequences backed by a small shadow model.
// ---------------------------------------------------------------------------
module tb_alu_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [31:0] rdata1, rdata2, wdata;
  logic        we;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_negative;

  alu_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raddr1       (raddr1),
    .rdata1       (rdata1),
    .raddr2       (raddr2),
    .rdata2       (rdata2),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_entry_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] act);
    sb_entry_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: got %h, required a pending expectation", act);
    end else begin
      e = sb_q.pop_front();
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", e.name, act, e.exp);
    end
  endtask

  // ---------------------------------------------------------------- ALU table
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        n;
  } alu_vec_t;

  alu_vec_t vecs[$];

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic z, input logic n);
    alu_vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.z = z; v.n = n;
    vecs.push_back(v);
  endtask

  logic [31:0] shadow [32];

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
    if (a != 5'd0) shadow[a] = d;
  endtask

  initial begin
    rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0;
    alu_src1 = '0; alu_src2 = '0; alu_op = 4'h0;

    // ------------------------------------------------ reset with pending write
    @(negedge clk);
    rst_n = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD;
    @(posedge clk); #1;
    rst_n = 1'b1; we = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      sb_push($sformatf("reset_rdata1[%0d]", i), 32'h0);
      sb_push($sformatf("reset_rdata2[%0d]", 31 - i), 32'h0);
      #1;
      $display("reset read r1=x%0d:%h r2=x%0d:%h", i, rdata1, 31 - i, rdata2);
      sb_check(rdata1);
      sb_check(rdata2);
    end
    raddr1 = 5'd5;
    sb_push("reset_x5_write_ignored", 32'h0);
    #1; sb_check(rdata1);

    // ------------------------------------------------ write/read, no bypass
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678; raddr1 = 5'd3;
    sb_push("x3_before_edge", 32'h0);
    #1; sb_check(rdata1);
    @(posedge clk); #1;
    we = 1'b0; shadow[3] = 32'h1234_5678;
    sb_push("x3_after_edge", 32'h1234_5678);
    $display("write x3=%h read %h", wdata, rdata1);
    sb_check(rdata1);

    // Overwrite x3 while port 2 reads it: the old value holds until the edge.
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_F00D; raddr2 = 5'd3;
    sb_push("x3_rdw_old", 32'h1234_5678);
    #1; sb_check(rdata2);
    @(posedge clk); #1;
    we = 1'b0; shadow[3] = 32'hCAFE_F00D;
    sb_push("x3_rdw_new", 32'hCAFE_F00D);
    $display("overwrite x3=%h read %h", wdata, rdata2);
    sb_check(rdata2);

    // A write to x0 is discarded.
    write_reg(5'd0, 32'hFFFF_FFFF);
    raddr2 = 5'd0;
    sb_push("x0_after_write", 32'h0);
    #1; $display("write x0=ffffffff read %h", rdata2);
    sb_check(rdata2);

    // Fill x1..x31 with distinct values, then read all of them back through both ports.
    for (int i = 1; i < 32; i++) write_reg(5'(i), {8'(i), 24'h5A_0000 ^ 24'(i * 32'h01_0203)});
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      sb_push($sformatf("fill_rdata1[%0d]", i), shadow[i]);
      sb_push($sformatf("fill_rdata2[%0d]", 31 - i), shadow[31 - i]);
      #1;
      $display("fill read r1=x%0d:%h r2=x%0d:%h", i, rdata1, 31 - i, rdata2);
      sb_check(rdata1);
      sb_check(rdata2);
    end

    // Reset clears the filled file.
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    raddr1 = 5'd17; raddr2 = 5'd31;
    sb_push("rereset_x17", 32'h0);
    sb_push("rereset_x31", 32'h0);
    #1; sb_check(rdata1); sb_check(rdata2);

    // ------------------------------------------------ ALU vectors
    add_vec(4'h0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0);
    add_vec(4'h0, 32'h7,         32'h8,         32'hF,         1'b0, 1'b0);
    add_vec(4'h1, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b1);
    add_vec(4'h1, 32'hA,         32'h3,         32'h7,         1'b0, 1'b0);
    add_vec(4'h3, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0);
    add_vec(4'h4, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0);
    add_vec(4'h3, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0);
    add_vec(4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0);
    add_vec(4'h4, 32'h1,         32'h2,         32'h1,         1'b0, 1'b0);
    add_vec(4'h2, 32'h1,         32'h0000_0024, 32'h10,        1'b0, 1'b0);
    add_vec(4'h2, 32'h1,         32'h1F,        32'h8000_0000, 1'b0, 1'b1);
    add_vec(4'h6, 32'h8000_0000, 32'd31,        32'h1,         1'b0, 1'b0);
    add_vec(4'h6, 32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0, 1'b0);
    add_vec(4'h7, 32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0, 1'b1);
    add_vec(4'h7, 32'h4000_0000, 32'h4,         32'h0400_0000, 1'b0, 1'b0);
    add_vec(4'h5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
    add_vec(4'h8, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b1);
    add_vec(4'h9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b1);
    add_vec(4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0);
    add_vec(4'hA, 32'h1234_5678, 32'h1,         32'h0,         1'b1, 1'b0);
    add_vec(4'hF, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      alu_op = vecs[i].op; alu_src1 = vecs[i].a; alu_src2 = vecs[i].b;
      sb_push($sformatf("alu%0d_op%h_result", i, vecs[i].op), vecs[i].res);
      sb_push($sformatf("alu%0d_op%h_zero", i, vecs[i].op), {31'b0, vecs[i].z});
      sb_push($sformatf("alu%0d_op%h_negative", i, vecs[i].op), {31'b0, vecs[i].n});
      #1;
      $display("alu op=%h a=%h b=%h result=%h zero=%b negative=%b",
               alu_op, alu_src1, alu_src2, alu_result, alu_zero, alu_negative);
      sb_check(alu_result);
      sb_check({31'b0, alu_zero});
      sb_check({31'b0, alu_negative});
    end

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: got %0d pending, required 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
